// File: rtl/bpsk_pkg.sv
// Shared types and defaults for the BPSK modulator.
package bpsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_SAMPLE_NUMBER = 256;
  localparam int DEF_SAMPLE_WIDTH  = 12;
  localparam int DEF_DATA_WIDTH    = 12;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int calcWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bpsk_bit_serializer.sv
// Latches the data word and walks it LSB-first, one bit per carrier period.
// Define BPSK_MOD_DIFF_EN to differentially encode the bit stream (DBPSK).
module bpsk_bit_serializer
  import bpsk_pkg::*;
#(
  parameter int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  localparam int CW           = calcWidth(SAMPLE_NUMBER),
  localparam int BW           = calcWidth(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_run,
  input  logic [CW-1:0]         i_cnt,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit,
  output logic                  o_boundary
);

  logic [DATA_WIDTH-1:0] r_sel;
  logic [BW-1:0]         r_selCnt;
  logic                  w_rawBit;
  logic                  w_lastBit;

  assign w_rawBit   = r_sel[r_selCnt];
  assign w_lastBit  = (r_selCnt == BW'(DATA_WIDTH - 1));
  assign o_boundary = i_run && (i_cnt == CW'(SAMPLE_NUMBER - 1));

`ifdef BPSK_MOD_DIFF_EN
  logic r_ref;

  assign o_bit = w_rawBit ^ r_ref;

  // The reference carries the previously transmitted symbol across words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref <= 1'b0;
    end else if (i_load) begin
      r_ref <= 1'b0;
    end else if (o_boundary) begin
      r_ref <= o_bit;
    end
  end
`else
  assign o_bit = w_rawBit;
`endif

  // Explicit wrap at the last bit keeps non-power-of-two word widths correct.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel    <= '0;
      r_selCnt <= '0;
    end else if (i_load) begin
      r_sel    <= i_data;
      r_selCnt <= '0;
    end else if (o_boundary) begin
      if (w_lastBit) begin
        r_sel    <= i_data;
        r_selCnt <= '0;
      end else begin
        r_selCnt <= r_selCnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/bpsk_mod.sv
// BPSK modulator: picks the positive or negated carrier sample per data bit.
// Define BPSK_MOD_DIFF_EN for differential BPSK (handled in the serializer).
module bpsk_mod
  import bpsk_pkg::*;
#(
  parameter int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
  parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  localparam int CW           = calcWidth(SAMPLE_NUMBER)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [SAMPLE_WIDTH-1:0] sine_in,
  input  logic [SAMPLE_WIDTH-1:0] neg_sine_in,
  input  logic [CW-1:0]           cnt_in,
  output logic [SAMPLE_WIDTH-1:0] signal_out
);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [SAMPLE_WIDTH-1:0] r_signalOut;
  logic                    w_load;
  logic                    w_run;
  logic                    w_bit;
  logic                    w_boundary;

  assign w_load     = (r_state == IDLE) && en;
  assign w_run      = (r_state == RUN) && en;
  assign signal_out = r_signalOut;

  bpsk_bit_serializer #(
    .SAMPLE_NUMBER(SAMPLE_NUMBER),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_run     (w_run),
    .i_cnt     (cnt_in),
    .i_data    (data),
    .o_bit     (w_bit),
    .o_boundary(w_boundary)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    w_nextState = en ? RUN : IDLE;
      RUN:     w_nextState = en ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Bit 1 sends the carrier as is, bit 0 sends it inverted; silent otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_signalOut <= '0;
    end else if (w_run) begin
      r_signalOut <= w_bit ? sine_in : neg_sine_in;
    end else begin
      r_signalOut <= '0;
    end
  end

endmodule

// File: tb/tb_bpsk_mod.sv
// Directed bench for bpsk_mod; adapts expected phases when BPSK_MOD_DIFF_EN is defined.
module tb_bpsk_mod;

  localparam int SN = 256;
  localparam int SW = 12;
  localparam int DW = 12;
`ifdef BPSK_MOD_DIFF_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] data;
  logic [SW-1:0] sine_in;
  logic [SW-1:0] neg_sine_in;
  logic [7:0]    cnt_in;
  logic [SW-1:0] signal_out;

  int   nVectors     = 0;
  int   nMiscompares = 0;
  logic diffRef      = 1'b0;

  bpsk_mod #(
    .SAMPLE_NUMBER(SN),
    .SAMPLE_WIDTH (SW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data       (data),
    .sine_in    (sine_in),
    .neg_sine_in(neg_sine_in),
    .cnt_in     (cnt_in),
    .signal_out (signal_out)
  );

  always #5 clk = ~clk;

  // Stand-in sine ROM: positive and negated samples are easy to tell apart.
  function automatic logic [SW-1:0] sineAt(input int c);
    return {4'h5, c[7:0]};
  endfunction

  function automatic logic [SW-1:0] negAt(input int c);
    return {4'hA, c[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveCnt(input int c);
    cnt_in      = c[7:0];
    sine_in     = sineAt(c);
    neg_sine_in = negAt(c);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b1;
    data = 12'hABC;
    for (int i = 0; i < 2; i++) begin
      driveCnt(37 + i);
      tick();
      nVectors++;
      if (signal_out !== '0) begin
        nMiscompares++;
        $display("[TB] FAIL reset_hold got %h expected 000", signal_out);
      end
    end
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      driveCnt(254 + i);
      tick();
      nVectors++;
      if (signal_out !== '0) begin
        nMiscompares++;
        $display("[TB] FAIL reset_idle got %h expected 000", signal_out);
      end
    end
  endtask

  task automatic test_basic_mapping();
    logic [SW-1:0] expVal;
    logic          t;
    en   = 1'b1;
    data = 12'h001;
    driveCnt(0);
    tick();
    nVectors++;
    if (signal_out !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL basic_load got %h expected 000", signal_out);
    end
    diffRef = 1'b0;
    for (int b = 0; b < DW; b++) begin
      t = (b == 0) ^ (DIFF & diffRef);
      for (int c = (b == 0) ? 1 : 0; c < SN; c++) begin
        driveCnt(c);
        tick();
        expVal = t ? sineAt(c) : negAt(c);
        nVectors++;
        if (signal_out !== expVal) begin
          nMiscompares++;
          $display("[TB] FAIL basic_map bit=%0d cnt=%0d got %h expected %h", b, c, signal_out, expVal);
        end
      end
      diffRef = t;
    end
    en = 1'b0;
    driveCnt(0);
    tick();
    nVectors++;
    if (signal_out !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL basic_stop got %h expected 000", signal_out);
    end
  endtask

  task automatic test_pattern_reload();
    logic [SW-1:0] expVal;
    logic [DW-1:0] word;
    logic          t;
    en   = 1'b1;
    data = 12'hA5A;
    driveCnt(0);
    tick();
    nVectors++;
    if (signal_out !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL pattern_load got %h expected 000", signal_out);
    end
    diffRef = 1'b0;
    for (int b = 0; b < DW + 2; b++) begin
      if (b == DW - 1) data = 12'hFFF;
      word = (b < DW) ? 12'hA5A : 12'hFFF;
      t = word[b % DW] ^ (DIFF & diffRef);
      for (int c = (b == 0) ? 1 : 0; c < SN; c++) begin
        driveCnt(c);
        tick();
        expVal = t ? sineAt(c) : negAt(c);
        nVectors++;
        if (signal_out !== expVal) begin
          nMiscompares++;
          $display("[TB] FAIL pattern bit=%0d cnt=%0d got %h expected %h", b, c, signal_out, expVal);
        end
      end
      diffRef = t;
    end
    en = 1'b0;
    driveCnt(0);
    tick();
  endtask

  task automatic test_enable_drop();
    logic [SW-1:0] expVal;
    logic          t;
    en   = 1'b1;
    data = 12'hFFF;
    driveCnt(0);
    tick();
    diffRef = 1'b0;
    for (int b = 0; b < 6; b++) begin
      t = 1'b1 ^ (DIFF & diffRef);
      for (int c = (b == 0) ? 1 : 0; c < ((b == 5) ? 100 : SN); c++) begin
        driveCnt(c);
        tick();
        expVal = t ? sineAt(c) : negAt(c);
        nVectors++;
        if (signal_out !== expVal) begin
          nMiscompares++;
          $display("[TB] FAIL drop_run bit=%0d cnt=%0d got %h expected %h", b, c, signal_out, expVal);
        end
      end
      if (b < 5) diffRef = t;
    end
    en = 1'b0;
    for (int c = 100; c < SN; c++) begin
      driveCnt(c);
      tick();
      nVectors++;
      if (signal_out !== '0) begin
        nMiscompares++;
        $display("[TB] FAIL drop_idle cnt=%0d got %h expected 000", c, signal_out);
      end
    end
    en   = 1'b1;
    data = 12'h000;
    driveCnt(0);
    tick();
    nVectors++;
    if (signal_out !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL drop_reload got %h expected 000", signal_out);
    end
    for (int b = 0; b < 2; b++) begin
      for (int c = (b == 0) ? 1 : 0; c < SN; c++) begin
        driveCnt(c);
        tick();
        nVectors++;
        if (signal_out !== negAt(c)) begin
          nMiscompares++;
          $display("[TB] FAIL drop_restart bit=%0d cnt=%0d got %h expected %h", b, c, signal_out, negAt(c));
        end
      end
    end
    en = 1'b0;
    driveCnt(0);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] expVal;
    logic [DW-1:0] word;
    logic          t;
    en   = 1'b1;
    data = 12'h0A5;
    word = 12'h0A5;
    driveCnt(0);
    tick();
    diffRef = 1'b0;
    for (int b = 0; b < 8; b++) begin
      t = word[b] ^ (DIFF & diffRef);
      for (int c = (b == 0) ? 1 : 0; c < ((b == 7) ? 50 : SN); c++) begin
        driveCnt(c);
        tick();
        expVal = t ? sineAt(c) : negAt(c);
        nVectors++;
        if (signal_out !== expVal) begin
          nMiscompares++;
          $display("[TB] FAIL rstmid_run bit=%0d cnt=%0d got %h expected %h", b, c, signal_out, expVal);
        end
      end
      diffRef = t;
    end
    rst  = 1'b1;
    data = 12'h002;
    word = 12'h002;
    driveCnt(50);
    tick();
    nVectors++;
    if (signal_out !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL rstmid_reset got %h expected 000", signal_out);
    end
    rst = 1'b0;
    driveCnt(51);
    tick();
    nVectors++;
    if (signal_out !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL rstmid_load got %h expected 000", signal_out);
    end
    diffRef = 1'b0;
    for (int b = 0; b < 3; b++) begin
      t = word[b] ^ (DIFF & diffRef);
      for (int c = (b == 0) ? 52 : 0; c < SN; c++) begin
        driveCnt(c);
        tick();
        expVal = t ? sineAt(c) : negAt(c);
        nVectors++;
        if (signal_out !== expVal) begin
          nMiscompares++;
          $display("[TB] FAIL rstmid_restart bit=%0d cnt=%0d got %h expected %h", b, c, signal_out, expVal);
        end
      end
      diffRef = t;
    end
    en = 1'b0;
    driveCnt(0);
    tick();
  endtask

`ifdef BPSK_MOD_DIFF_EN
  task automatic test_diff();
    logic [SW-1:0] expVal;
    en   = 1'b1;
    data = 12'hFFF;
    driveCnt(0);
    tick();
    for (int k = 0; k < DW; k++) begin
      for (int c = (k == 0) ? 1 : 0; c < SN; c++) begin
        driveCnt(c);
        tick();
        expVal = (k % 2 == 0) ? sineAt(c) : negAt(c);
        nVectors++;
        if (signal_out !== expVal) begin
          nMiscompares++;
          $display("[TB] FAIL diff_ones period=%0d cnt=%0d got %h expected %h", k, c, signal_out, expVal);
        end
      end
    end
    en = 1'b0;
    driveCnt(0);
    tick();
    en   = 1'b1;
    data = 12'h000;
    driveCnt(0);
    tick();
    for (int k = 0; k < DW; k++) begin
      for (int c = (k == 0) ? 1 : 0; c < SN; c++) begin
        driveCnt(c);
        tick();
        nVectors++;
        if (signal_out !== negAt(c)) begin
          nMiscompares++;
          $display("[TB] FAIL diff_zeros period=%0d cnt=%0d got %h expected %h", k, c, signal_out, negAt(c));
        end
      end
    end
    en = 1'b0;
    driveCnt(0);
    tick();
  endtask
`endif

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    data = '0;
    driveCnt(0);
    test_reset();
    test_basic_mapping();
    test_pattern_reload();
    test_enable_drop();
    test_reset_mid();
`ifdef BPSK_MOD_DIFF_EN
    test_diff();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/bpsk_mod.md
Name: bpsk_mod

Overview:
- Binary phase-shift keying modulator for the transmit path.
- Serialises a DATA_WIDTH-bit word one bit per carrier period.
- Per sample, selects either the positive or the negated carrier sample supplied by an external sine ROM, which is indexed by the shared sample counter cnt_in.
- Output is registered and feeds the DAC/transmit chain.

Parameters:
- SAMPLE_NUMBER, 256: samples per carrier period. Power of two. cnt_in width CW = $clog2(SAMPLE_NUMBER).
- SAMPLE_WIDTH, 12: width of the carrier samples and of signal_out.
- DATA_WIDTH, 12: bits per data word. Bit-counter width BW = $clog2(DATA_WIDTH), minimum 1.

Ports:
- clk, input, 1: sole clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: modulation enable.
- data, input, DATA_WIDTH: word to transmit. Sampled only at word load.
- sine_in, input, SAMPLE_WIDTH: carrier sample for phase 0, index cnt_in.
- neg_sine_in, input, SAMPLE_WIDTH: carrier sample for phase 180°, index cnt_in.
- cnt_in, input, CW: current carrier sample index. Wraps SAMPLE_NUMBER-1 -> 0.
- signal_out, output, SAMPLE_WIDTH: modulated sample, registered.

Behaviour:
- Internal registers: sel (DATA_WIDTH, latched word), sel_cnt (BW, current bit index), state in {IDLE, RUN}.
- Reset (rst=1 at a clock edge), which overrides everything including en:
  - signal_out = 0, sel = 0, sel_cnt = 0, state = IDLE.
- IDLE:
  - signal_out <= 0.
  - If en=1: sel <= data, sel_cnt <= 0, state <= RUN.
- RUN with en=1, each cycle:
  - signal_out <= sel[sel_cnt] ? sine_in : neg_sine_in. Bit 1 = phase 0, bit 0 = phase 180°. LSB transmitted first.
  - Latency: one clock from sine_in/neg_sine_in/cnt_in to signal_out.
- Symbol boundary: cnt_in == SAMPLE_NUMBER-1 while in RUN with en=1.
  - If sel_cnt < DATA_WIDTH-1: sel_cnt <= sel_cnt+1.
  - If sel_cnt == DATA_WIDTH-1: sel_cnt <= 0 and sel <= data. Back-to-back words, no gap sample.
  - The sample output on the boundary cycle still uses the old bit. The new bit applies from the next cycle, i.e. cnt_in = 0.
- RUN with en=0: state <= IDLE, signal_out <= 0, sel and sel_cnt hold. Re-enabling reloads data and restarts at bit 0.
- The first symbol after entering RUN may be partial if cnt_in is not 0 when en rises. The block does not align to cnt_in. Upstream asserts en at cnt_in = 0 when alignment matters.
- Changes on data are ignored except at a load (IDLE->RUN transition or last-bit boundary).
- Non-power-of-two DATA_WIDTH: sel_cnt wraps explicitly at DATA_WIDTH-1, never at 2^BW.
- No arithmetic on samples; pure selection, so no width growth.

Optional Feature:
- Macro BPSK_MOD_DIFF_EN selects differential BPSK (DBPSK).
- Defined:
  - Adds a 1-bit register ref, reset to 0 and cleared on IDLE->RUN.
  - Transmitted bit t = sel[sel_cnt] XOR ref, and signal_out uses t in place of the raw bit.
  - At each symbol boundary, ref <= t.
- Undefined: plain BPSK as above. No ref register exists.

Decomposition:
- Package bpsk_pkg: state enum type (IDLE, RUN), default parameter constants (SAMPLE_NUMBER=256, SAMPLE_WIDTH=12, DATA_WIDTH=12), and a function computing counter widths.
- One natural sub-module: bpsk_bit_serializer. It owns sel, sel_cnt and the load/advance logic, and outputs the current bit and the symbol boundary. The top module keeps the FSM, the sample mux and the output register.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 and arbitrary inputs -> signal_out = 0, sel_cnt = 0, sel = 0 throughout; IDLE on release.
- Basic mapping: data = 12'h001, en raised at cnt_in = 0, cnt_in sweeping 0..255 with sine ROM values.
  - First 256 outputs equal sine_in delayed by 1 cycle (bit0 = 1).
  - Next 11 periods equal neg_sine_in.
- Pattern/word reload: data = 12'hA5A, run 12 periods.
  - sel_cnt steps 0..11, changing the cycle after cnt_in = 255.
  - Phase sequence LSB-first is 0,1,0,1,1,0,1,0,0,1,0,1 -> neg,pos,neg,pos,pos,neg,pos,neg,neg,pos,neg,pos.
  - On wrap, sel reloads the current data (changed to 12'hFFF) -> all-positive periods follow.
- Enable drop: deassert en mid-period at bit 5.
  - signal_out = 0 on the next cycle.
  - Re-asserting en with data = 12'h000 -> neg_sine_in from bit 0.
- Reset mid-operation: rst=1 during bit 7 -> next cycle signal_out = 0 and sel_cnt = 0. After release with en=1, transmission restarts at bit 0 of the current data.
- With BPSK_MOD_DIFF_EN, data = 12'hFFF -> phases alternate pos,neg,pos,... per period. data = 12'h000 -> neg for all 12 periods.
